regfile_writeback_queue: RTL and testbench
==========================================

Name: regfile_writeback_queue

Overview:
- Producer-side front end for the 32x32 MIPS register file's single synchronous write port.
- Buffers register writebacks from two producers: ALU results (port A) and load results (port B).
- Drains one entry per cycle onto the write port (RegWrite/WriteRegister/WriteData); can be held off while another agent owns the port.
- Forwards pending, not-yet-written values to both read-port addresses, so readers never see stale data.

Parameters:
DEPTH, 4, number of queue entries (power of two, >=2)
WIDTH, 32, data width
ADDRW, 5, register address width

Ports:
Clk  input  1  clock, positive edge
Reset_n  input  1  asynchronous active-low reset
AValid  input  1  ALU producer has a writeback
AAddr  input  ADDRW  ALU destination register
AData  input  WIDTH  ALU result
AReady  output  1  ALU writeback accepted this edge
BValid  input  1  load producer has a writeback
BAddr  input  ADDRW  load destination register
BData  input  WIDTH  load result
BReady  output  1  load writeback accepted this edge
WrHold  input  1  another agent owns the write port; do not drain
RegWrite  output  1  write enable to register file
WriteRegister  output  ADDRW  address to register file
WriteData  output  WIDTH  data to register file
ReadRegister1  input  ADDRW  read-port-1 address (shared with register file)
ReadRegister2  input  ADDRW  read-port-2 address
Fwd1Hit  output  1  pending write matches ReadRegister1
Fwd1Data  output  WIDTH  newest pending data for ReadRegister1
Fwd2Hit  output  1  same for port 2
Fwd2Data  output  WIDTH  same for port 2
Count  output  clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async, Reset_n low): Count=0, read/write pointers=0, all entries invalid. Outputs: RegWrite=0, Fwd1Hit=Fwd2Hit=0, AReady=BReady=0. Reset mid-operation discards pending entries without writing them.
- Storage: circular FIFO of DEPTH entries {addr, data}. Pointers wrap modulo DEPTH. Count counts 0..DEPTH.
- Enqueue: at most one per edge; B has fixed priority over A.
  - BReady = Reset_n && (Count<DEPTH).
  - AReady = Reset_n && (Count<DEPTH) && !BValid.
  - Handshake completes on an edge where Valid&&Ready; the producer holds Addr/Data stable until then.
  - Ready depends only on Count and BValid, never on the same-cycle pop. A full queue refuses even while popping.
- Register $0 writes: a handshake with addr==0 completes normally but nothing is stored; Count is unchanged.
- Drain:
  - RegWrite = (Count!=0) && !WrHold, combinational.
  - WriteRegister/WriteData = head entry (zeros when empty).
  - Pop occurs at the edge where RegWrite=1, the same edge at which the register file captures the write.
- Latency: an entry accepted at edge N appears on the write port after N and is written at edge N+1 at the earliest.
- Simultaneous push and pop: Count unchanged, both pointers advance.
- FIFO order is preserved; two entries for the same address are written in acceptance order.
- Forwarding (combinational):
  - Search all valid entries, including the head being presented this cycle.
  - FwdxHit=1 if any entry addr==ReadRegisterx and ReadRegisterx!=0.
  - FwdxData = data of the newest matching entry (closest to the tail), else 0.
  - Entries accepted on the current edge are not visible until after it.
- WrHold may toggle at any time. It affects only RegWrite and pop; it does not affect enqueue or forwarding.

Test Plan:
- Reset: Reset_n low mid-run with Count=3 -> Count=0, RegWrite=0, Fwd hits 0 immediately (asynchronous). After release, AReady=1.
- Single write: A writes (addr 5, 0xDEADBEEF) at edge 1 -> cycle after edge 1: RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF, Fwd1Hit=1 with ReadRegister1=5. After edge 2: Count=0, Fwd1Hit=0.
- Priority and $0: AValid and BValid both high -> BReady=1, AReady=0; B drains first. A write to addr 0 handshakes, Count stays 0, RegWrite stays 0.
- Full and hold: WrHold=1, push 4 entries -> Count=4, AReady=BReady=0. Release WrHold -> entries 1..4 appear in order on 4 consecutive cycles with RegWrite=1.
- Forward newest: with WrHold=1, push (7,0x11) then (7,0x22); ReadRegister2=7 -> Fwd2Hit=1, Fwd2Data=0x22. Register 7 receives 0x11 then 0x22.
- Wrap: 10 push/pop cycles with simultaneous push and pop -> Count constant at 1; data order intact across pointer wrap.

Source files
------------

// File: rtl/regfile_writeback_queue_if.sv
// regfile_writeback_queue_if: producer, write-port and forwarding signals of the writeback queue
interface regfile_writeback_queue_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int ADDRW = 5
);
    logic                     AValid;
    logic [ADDRW-1:0]         AAddr;
    logic [WIDTH-1:0]         AData;
    logic                     AReady;
    logic                     BValid;
    logic [ADDRW-1:0]         BAddr;
    logic [WIDTH-1:0]         BData;
    logic                     BReady;
    logic                     WrHold;
    logic                     RegWrite;
    logic [ADDRW-1:0]         WriteRegister;
    logic [WIDTH-1:0]         WriteData;
    logic [ADDRW-1:0]         ReadRegister1;
    logic [ADDRW-1:0]         ReadRegister2;
    logic                     Fwd1Hit;
    logic [WIDTH-1:0]         Fwd1Data;
    logic                     Fwd2Hit;
    logic [WIDTH-1:0]         Fwd2Data;
    logic [$clog2(DEPTH):0]   Count;

    modport master (
        output AValid, AAddr, AData, BValid, BAddr, BData, WrHold, ReadRegister1, ReadRegister2,
        input  AReady, BReady, RegWrite, WriteRegister, WriteData, Fwd1Hit, Fwd1Data, Fwd2Hit, Fwd2Data, Count
    );
    modport slave (
        input  AValid, AAddr, AData, BValid, BAddr, BData, WrHold, ReadRegister1, ReadRegister2,
        output AReady, BReady, RegWrite, WriteRegister, WriteData, Fwd1Hit, Fwd1Data, Fwd2Hit, Fwd2Data, Count
    );
endinterface

// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue: two-producer writeback FIFO draining into the register file write port with read forwarding
module regfile_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int ADDRW = 5
) (
    input logic Clk,
    input logic Reset_n,
    regfile_writeback_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    logic [ADDRW-1:0] addr_q [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      count;
    logic [PW-1:0]    idx;
    logic             not_full;
    logic             push;
    logic             store;
    logic             pop;
    logic [ADDRW-1:0] in_addr;
    logic [WIDTH-1:0] in_data;

    assign not_full   = count < (PW+1)'(DEPTH);
    assign bus.BReady = Reset_n && not_full;
    assign bus.AReady = Reset_n && not_full && !bus.BValid;
    assign bus.Count  = count;

    // B wins the single enqueue slot; $0 writes handshake but are dropped
    always_comb begin
        push    = (bus.BValid && bus.BReady) || (bus.AValid && bus.AReady);
        in_addr = bus.BValid ? bus.BAddr : bus.AAddr;
        in_data = bus.BValid ? bus.BData : bus.AData;
        store   = push && (in_addr != '0);
        pop     = bus.RegWrite;
    end

    // head of queue drives the write port unless another agent holds it
    always_comb begin
        bus.RegWrite      = (count != '0) && !bus.WrHold;
        bus.WriteRegister = (count != '0) ? addr_q[rd_ptr] : '0;
        bus.WriteData     = (count != '0) ? data_q[rd_ptr] : '0;
    end

    // scan oldest to newest so the last match leaves the newest pending value
    always_comb begin
        bus.Fwd1Hit  = 1'b0;
        bus.Fwd1Data = '0;
        bus.Fwd2Hit  = 1'b0;
        bus.Fwd2Data = '0;
        idx          = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if ((PW+1)'(i) < count) begin
                if (bus.ReadRegister1 != '0 && addr_q[idx] == bus.ReadRegister1) begin
                    bus.Fwd1Hit  = 1'b1;
                    bus.Fwd1Data = data_q[idx];
                end
                if (bus.ReadRegister2 != '0 && addr_q[idx] == bus.ReadRegister2) begin
                    bus.Fwd2Hit  = 1'b1;
                    bus.Fwd2Data = data_q[idx];
                end
            end
        end
    end

    // pointers and occupancy; reset discards pending entries unwritten
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            wr_ptr <= store ? wr_ptr + 1'b1 : wr_ptr;
            count  <= count + (PW+1)'(store) - (PW+1)'(pop);
        end
    end

    // entry payload needs no reset; validity comes from count
    always_ff @(posedge Clk) begin
        if (store) begin
            addr_q[wr_ptr] <= in_addr;
            data_q[wr_ptr] <= in_data;
        end
    end
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb_regfile_writeback_queue: directed scenario checks of the writeback queue
module tb_regfile_writeback_queue;
    logic Clk;
    logic Reset_n;
    int   tests;
    int   fails;

    regfile_writeback_queue_if #(.DEPTH(4), .WIDTH(32), .ADDRW(5)) q ();

    regfile_writeback_queue #(.DEPTH(4), .WIDTH(32), .ADDRW(5)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (q.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_a(input logic [4:0] a, input logic [31:0] d);
        q.AValid = 1'b1;
        q.AAddr  = a;
        q.AData  = d;
        @(negedge Clk);
        q.AValid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #1;
        tests++; if (q.Count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d expected 0", q.Count); end
        tests++; if (q.RegWrite !== 1'b0) begin fails++; $display("FAIL reset_regwrite got %b expected 0", q.RegWrite); end
        tests++; if (q.AReady !== 1'b0 || q.BReady !== 1'b0) begin fails++; $display("FAIL reset_ready got %b%b expected 00", q.AReady, q.BReady); end
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        tests++; if (q.AReady !== 1'b1) begin fails++; $display("FAIL release_aready got %b expected 1", q.AReady); end
    endtask

    task automatic test_single_write();
        q.WrHold        = 1'b0;
        q.ReadRegister1 = 5'd5;
        push_a(5'd5, 32'hDEADBEEF);
        tests++; if (q.RegWrite !== 1'b1) begin fails++; $display("FAIL single_regwrite got %b expected 1", q.RegWrite); end
        tests++; if (q.WriteRegister !== 5'd5) begin fails++; $display("FAIL single_addr got %0d expected 5", q.WriteRegister); end
        tests++; if (q.WriteData !== 32'hDEADBEEF) begin fails++; $display("FAIL single_data got %h expected deadbeef", q.WriteData); end
        tests++; if (q.Fwd1Hit !== 1'b1 || q.Fwd1Data !== 32'hDEADBEEF) begin fails++; $display("FAIL single_fwd got %b/%h expected 1/deadbeef", q.Fwd1Hit, q.Fwd1Data); end
        @(negedge Clk);
        #1;
        tests++; if (q.Count !== 3'd0 || q.Fwd1Hit !== 1'b0) begin fails++; $display("FAIL single_drained got count %0d hit %b expected 0/0", q.Count, q.Fwd1Hit); end
    endtask

    task automatic test_priority_zero();
        q.WrHold = 1'b1;
        q.AValid = 1'b1; q.AAddr = 5'd3; q.AData = 32'hA;
        q.BValid = 1'b1; q.BAddr = 5'd4; q.BData = 32'hB;
        #1;
        tests++; if (q.BReady !== 1'b1 || q.AReady !== 1'b0) begin fails++; $display("FAIL prio_ready got B%b A%b expected B1 A0", q.BReady, q.AReady); end
        @(negedge Clk);
        q.BValid = 1'b0;
        #1;
        tests++; if (q.AReady !== 1'b1 || q.Count !== 3'd1) begin fails++; $display("FAIL prio_after_b got A%b count %0d expected A1 count 1", q.AReady, q.Count); end
        @(negedge Clk);
        q.AValid = 1'b0;
        q.WrHold = 1'b0;
        #1;
        tests++; if (q.WriteRegister !== 5'd4 || q.WriteData !== 32'hB) begin fails++; $display("FAIL prio_first got %0d/%h expected 4/b", q.WriteRegister, q.WriteData); end
        @(negedge Clk);
        #1;
        tests++; if (q.WriteRegister !== 5'd3 || q.WriteData !== 32'hA) begin fails++; $display("FAIL prio_second got %0d/%h expected 3/a", q.WriteRegister, q.WriteData); end
        @(negedge Clk);
        #1;
        q.AValid = 1'b1; q.AAddr = 5'd0; q.AData = 32'h55;
        #1;
        tests++; if (q.AReady !== 1'b1) begin fails++; $display("FAIL zero_ready got %b expected 1", q.AReady); end
        @(negedge Clk);
        q.AValid = 1'b0;
        #1;
        tests++; if (q.Count !== 3'd0 || q.RegWrite !== 1'b0) begin fails++; $display("FAIL zero_dropped got count %0d regwrite %b expected 0/0", q.Count, q.RegWrite); end
    endtask

    task automatic test_full_hold();
        q.WrHold = 1'b1;
        for (int i = 1; i <= 4; i++) push_a(5'(i), 32'h100 + 32'(i));
        tests++; if (q.Count !== 3'd4) begin fails++; $display("FAIL full_count got %0d expected 4", q.Count); end
        tests++; if (q.AReady !== 1'b0 || q.BReady !== 1'b0) begin fails++; $display("FAIL full_ready got A%b B%b expected 0 0", q.AReady, q.BReady); end
        q.WrHold = 1'b0;
        q.AValid = 1'b1; q.AAddr = 5'd9; q.AData = 32'h9;
        #1;
        tests++; if (q.AReady !== 1'b0 || q.RegWrite !== 1'b1) begin fails++; $display("FAIL full_popping got ready %b regwrite %b expected 0/1", q.AReady, q.RegWrite); end
        q.AValid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            tests++; if (q.RegWrite !== 1'b1 || q.WriteRegister !== 5'(i) || q.WriteData !== 32'h100 + 32'(i)) begin
                fails++; $display("FAIL full_drain_%0d got %b/%0d/%h expected 1/%0d/%h", i, q.RegWrite, q.WriteRegister, q.WriteData, i, 32'h100 + 32'(i));
            end
            @(negedge Clk);
        end
        #1;
        tests++; if (q.Count !== 3'd0 || q.RegWrite !== 1'b0) begin fails++; $display("FAIL full_empty got count %0d regwrite %b expected 0/0", q.Count, q.RegWrite); end
    endtask

    task automatic test_forward_newest();
        q.WrHold        = 1'b1;
        q.ReadRegister1 = 5'd8;
        q.ReadRegister2 = 5'd7;
        push_a(5'd7, 32'h11);
        push_a(5'd7, 32'h22);
        tests++; if (q.Fwd2Hit !== 1'b1 || q.Fwd2Data !== 32'h22) begin fails++; $display("FAIL fwd_newest got %b/%h expected 1/22", q.Fwd2Hit, q.Fwd2Data); end
        tests++; if (q.Fwd1Hit !== 1'b0 || q.Fwd1Data !== 32'h0) begin fails++; $display("FAIL fwd_miss got %b/%h expected 0/0", q.Fwd1Hit, q.Fwd1Data); end
        q.WrHold = 1'b0;
        #1;
        tests++; if (q.WriteRegister !== 5'd7 || q.WriteData !== 32'h11) begin fails++; $display("FAIL fwd_write1 got %0d/%h expected 7/11", q.WriteRegister, q.WriteData); end
        @(negedge Clk);
        #1;
        tests++; if (q.WriteRegister !== 5'd7 || q.WriteData !== 32'h22 || q.Fwd2Data !== 32'h22) begin fails++; $display("FAIL fwd_write2 got %0d/%h fwd %h expected 7/22 fwd 22", q.WriteRegister, q.WriteData, q.Fwd2Data); end
        @(negedge Clk);
        #1;
        tests++; if (q.Count !== 3'd0 || q.Fwd2Hit !== 1'b0) begin fails++; $display("FAIL fwd_empty got count %0d hit %b expected 0/0", q.Count, q.Fwd2Hit); end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  ea;
        logic [31:0] ed;
        q.WrHold = 1'b0;
        push_a(5'd10, 32'h1000);
        for (int k = 0; k < 10; k++) begin
            ea = (k == 0) ? 5'd10 : 5'(10 + k);
            ed = (k == 0) ? 32'h1000 : 32'h2000 + 32'(k - 1);
            q.AValid = 1'b1; q.AAddr = 5'(11 + k); q.AData = 32'h2000 + 32'(k);
            #1;
            tests++; if (q.Count !== 3'd1 || q.WriteRegister !== ea || q.WriteData !== ed) begin
                fails++; $display("FAIL wrap_%0d got count %0d %0d/%h expected 1 %0d/%h", k, q.Count, q.WriteRegister, q.WriteData, ea, ed);
            end
            @(negedge Clk);
        end
        q.AValid = 1'b0;
        #1;
        tests++; if (q.Count !== 3'd1 || q.WriteRegister !== 5'd20 || q.WriteData !== 32'h2009) begin fails++; $display("FAIL wrap_last got count %0d %0d/%h expected 1 20/2009", q.Count, q.WriteRegister, q.WriteData); end
        @(negedge Clk);
        #1;
        tests++; if (q.Count !== 3'd0) begin fails++; $display("FAIL wrap_empty got %0d expected 0", q.Count); end
    endtask

    task automatic test_midrun_reset();
        q.WrHold = 1'b1;
        push_a(5'd1, 32'h71);
        push_a(5'd2, 32'h72);
        push_a(5'd3, 32'h73);
        q.ReadRegister1 = 5'd2;
        q.WrHold = 1'b0;
        #1;
        tests++; if (q.Count !== 3'd3 || q.RegWrite !== 1'b1 || q.Fwd1Hit !== 1'b1) begin fails++; $display("FAIL midrst_pre got count %0d regwrite %b hit %b expected 3/1/1", q.Count, q.RegWrite, q.Fwd1Hit); end
        Reset_n = 1'b0;
        #1;
        tests++; if (q.Count !== 3'd0 || q.RegWrite !== 1'b0 || q.Fwd1Hit !== 1'b0 || q.AReady !== 1'b0) begin
            fails++; $display("FAIL midrst_async got count %0d regwrite %b hit %b aready %b expected 0/0/0/0", q.Count, q.RegWrite, q.Fwd1Hit, q.AReady);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        tests++; if (q.AReady !== 1'b1 || q.Count !== 3'd0 || q.RegWrite !== 1'b0) begin fails++; $display("FAIL midrst_release got aready %b count %0d regwrite %b expected 1/0/0", q.AReady, q.Count, q.RegWrite); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        Reset_n = 1'b0;
        q.AValid = 1'b0; q.AAddr = '0; q.AData = '0;
        q.BValid = 1'b0; q.BAddr = '0; q.BData = '0;
        q.WrHold = 1'b0;
        q.ReadRegister1 = '0;
        q.ReadRegister2 = '0;
        test_reset();
        test_single_write();
        test_priority_zero();
        test_full_hold();
        test_forward_newest();
        test_back_to_back();
        test_midrun_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
